// File: rtl/rst_sequencer.sv
// -----------------------------------------------------------------------------
// rst_sequencer
//
// Reset generator for the multiplier datapath and its neighbours. The board
// reset is synchronised through a flop chain, all channel resets are held low
// for a minimum trigger-free interval, and the channels are then released one
// at a time with a fixed stagger. Once every channel is out of reset the block
// sits in RUN, where a global software reset restarts the whole sequence and
// per-channel requests pulse a single channel's reset without disturbing the
// others.
//
// Parameters:
//   SYNC_STAGES  depth of the ext_rst_n synchroniser (>= 2)
//   NUM_CH       number of reset output channels (>= 1)
//   HOLD_CYCLES  trigger-free cycles before channel 0 releases; also the
//                length of a local channel reset (>= 1)
//   STAGGER      cycles between consecutive channel releases (>= 1)
//
// Ports:
//   clk          single clock, all state changes on its rising edge
//   reset        synchronous active-high block reset
//   ext_rst_n    asynchronous active-low board reset
//   sw_rst_req   synchronous global reset request (one-cycle pulse suffices)
//   ch_rst_req   synchronous per-channel local reset request, honoured in RUN
//   rst_n        active-low reset per downstream channel (registered)
//   done         high in RUN while every rst_n bit is high
// -----------------------------------------------------------------------------
module rst_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGGER     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ext_rst_n,
    input  logic              sw_rst_req,
    input  logic [NUM_CH-1:0] ch_rst_req,
    output logic [NUM_CH-1:0] rst_n,
    output logic              done
);

    // Shared counter must reach the larger of the hold and stagger intervals.
    localparam int unsigned MAX_CNT = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
    localparam int unsigned CW      = $clog2(MAX_CNT + 1);
    localparam int unsigned IW      = $clog2(NUM_CH) + 1;
    localparam int unsigned LW      = $clog2(HOLD_CYCLES + 1);

    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAG_LAST  = CW'(STAGGER - 1);
    localparam logic [LW-1:0] LHOLD_LAST = LW'(HOLD_CYCLES - 1);
    localparam logic [IW-1:0] LAST_CH    = IW'(NUM_CH - 1);
    localparam logic [IW-1:0] FIRST_IDX  = IW'(1);

    typedef enum logic [1:0] {
        StAssert,
        StRelease,
        StRun
    } state_t;

    // -------------------------------------------------------------------------
    // Board reset synchroniser. Cleared to 0 so that downstream logic sees the
    // board reset as asserted until the chain has refilled with ones.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ext_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ext_rst_n};
        end
    end

    assign ext_sync = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Sequencer state
    // -------------------------------------------------------------------------
    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     idx_q;
    logic [NUM_CH-1:0] rst_n_q;
    logic [LW-1:0]     lcnt_q [NUM_CH];

    logic trigger;

    assign trigger = reset | ~ext_sync | sw_rst_req;

    // Single-process FSM. Any trigger forces a full restart from StAssert and
    // also cancels every local reset in flight, since all channels go low.
    //
    // In StRun every channel has been released, so a low rst_n_q bit means a
    // local reset for that channel is in progress; no separate busy flag is
    // kept.
    always_ff @(posedge clk) begin
        if (trigger) begin
            state_q <= StAssert;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                lcnt_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StAssert: begin
                    if (cnt_q == HOLD_LAST) begin
                        rst_n_q[0] <= 1'b1;
                        cnt_q      <= '0;
                        idx_q      <= FIRST_IDX;
                        state_q    <= (NUM_CH == 1) ? StRun : StRelease;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StRelease: begin
                    if (cnt_q == STAG_LAST) begin
                        for (int i = 0; i < int'(NUM_CH); i++) begin
                            if (idx_q == IW'(i)) begin
                                rst_n_q[i] <= 1'b1;
                            end
                        end
                        cnt_q <= '0;
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == LAST_CH) begin
                            state_q <= StRun;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StRun: begin
                    for (int i = 0; i < int'(NUM_CH); i++) begin
                        if (ch_rst_req[i]) begin
                            // New or repeated request restarts the pulse.
                            rst_n_q[i] <= 1'b0;
                            lcnt_q[i]  <= '0;
                        end else if (!rst_n_q[i]) begin
                            if (lcnt_q[i] == LHOLD_LAST) begin
                                rst_n_q[i] <= 1'b1;
                                lcnt_q[i]  <= '0;
                            end else begin
                                lcnt_q[i] <= lcnt_q[i] + 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state_q <= StAssert;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    rst_n_q <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: rst_n straight from flops, done a single AND of flop outputs.
    // -------------------------------------------------------------------------
    assign rst_n = rst_n_q;
    assign done  = (state_q == StRun) & (&rst_n_q);

endmodule
